// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller and the RISC-V datapath.
// master = controller side, slave = datapath side.
interface multicycle_controller_if #(
    parameter int STATE_W = 4
);
    // Instruction fields and status from the datapath
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic               funct7_5;
    logic               zero;

    // Mux selects and enables back into the datapath
    logic               PCWrite;
    logic               AdrSrc;
    logic               MemWrite;
    logic               IRWrite;
    logic [1:0]         ResultSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ImmSrc;
    logic               RegWrite;
    logic [2:0]         ALUControl;
    logic [STATE_W-1:0] state;

    modport master (
        input  opcode, funct3, funct7_5, zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, state
    );

    modport slave (
        output opcode, funct3, funct7_5, zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
               ALUSrcB, ImmSrc, RegWrite, ALUControl, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore sequencing FSM for the multi-cycle RISC-V datapath with embedded ALU and
// immediate decoders. Optional macro BNE_EN adds bne on the beq datapath path.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_controller_if.master bus
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_e;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_ctrl_e;

    state_e    state_q, state_d;
    alu_op_e   alu_op;
    alu_ctrl_e alu_control;

    logic       pc_update;
    logic       branch;
    logic       branch_cond;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values; blocking here would create simulation races.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output is defaulted before the case so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d    = S_FETCH;
        pc_update  = 1'b0;
        branch     = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = ALUOP_ADD;

        case (state_q)
            S_FETCH: begin
                state_d    = S_DECODE;
                ir_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                // ALU precomputes OldPC + imm so a taken branch has its target ready
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_IALU:      state_d = S_EXECI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
                state_d   = S_ALUWB;
            end
            S_JAL: begin
                // PC <- branch target from DECODE while ALU forms OldPC + 4 for rd
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_SUB;
                branch    = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

`ifdef BNE_EN
    assign branch_cond = bus.funct3[0] ? ~bus.zero : bus.zero;
`else
    assign branch_cond = bus.zero;
`endif

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (bus.funct3)
                    // Only R-type (opcode[5]=1) may subtract; addi ignores instr[30]
                    3'b000:  alu_control = (bus.opcode[5] & bus.funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        case (bus.opcode)
            OP_SW:   imm_src = 2'b01;
            OP_BEQ:  imm_src = 2'b10;
            OP_JAL:  imm_src = 2'b11;
            default: imm_src = 2'b00;
        endcase
    end

    // Write enables are masked while reset is high so an abandoned instruction
    // cannot commit anything in the reset cycle.
    assign bus.PCWrite    = ~reset & (pc_update | (branch & branch_cond));
    assign bus.IRWrite    = ~reset & ir_write;
    assign bus.RegWrite   = ~reset & reg_write;
    assign bus.MemWrite   = ~reset & mem_write;
    assign bus.AdrSrc     = adr_src;
    assign bus.ResultSrc  = result_src;
    assign bus.ALUSrcA    = alu_src_a;
    assign bus.ALUSrcB    = alu_src_b;
    assign bus.ImmSrc     = imm_src;
    assign bus.ALUControl = alu_control;
    assign bus.state      = STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized self-checking bench for multicycle_controller: each instruction is
// expanded into its expected per-cycle control script and compared cycle by cycle.
module tb_multicycle_controller;

    localparam int STATE_W = 4;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IALU = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    localparam logic [2:0] A_ADD = 3'b000;
    localparam logic [2:0] A_SUB = 3'b001;
    localparam logic [2:0] A_AND = 3'b010;
    localparam logic [2:0] A_OR  = 3'b011;
    localparam logic [2:0] A_SLT = 3'b101;

    logic clk;
    logic reset;

    multicycle_controller_if #(.STATE_W(STATE_W)) bus ();

    multicycle_controller #(.STATE_W(STATE_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One expected cycle of an instruction's execution
    typedef struct {
        int         st;
        bit         pcu;
        bit         br;
        bit         adr;
        bit         mw;
        bit         irw;
        bit [1:0]   rs;
        bit [1:0]   a;
        bit [1:0]   b;
        bit         rw;
        bit [2:0]   alu;
    } cyc_t;

    cyc_t script[$];

    function automatic cyc_t mk(int st, bit pcu, bit br, bit adr, bit mw, bit irw,
                                bit [1:0] rs, bit [1:0] a, bit [1:0] b, bit rw, bit [2:0] alu);
        cyc_t c;
        c.st = st; c.pcu = pcu; c.br = br; c.adr = adr; c.mw = mw; c.irw = irw;
        c.rs = rs; c.a = a; c.b = b; c.rw = rw; c.alu = alu;
        return c;
    endfunction

    function automatic bit [2:0] alu_expect(bit [2:0] f3, bit is_r, bit f7);
        case (f3)
            3'b000:  return (is_r && f7) ? A_SUB : A_ADD;
            3'b010:  return A_SLT;
            3'b110:  return A_OR;
            3'b111:  return A_AND;
            default: return A_ADD;
        endcase
    endfunction

    function automatic bit [1:0] imm_expect(bit [6:0] op);
        if (op == OP_SW)  return 2'b01;
        if (op == OP_BEQ) return 2'b10;
        if (op == OP_JAL) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit taken(bit z, bit [2:0] f3);
`ifdef BNE_EN
        return f3[0] ? !z : z;
`else
        return z;
`endif
    endfunction

    function automatic bit is_legal(bit [6:0] op);
        return op == OP_LW || op == OP_SW || op == OP_R || op == OP_IALU ||
               op == OP_JAL || op == OP_BEQ;
    endfunction

    // Expand an instruction into its cycle-by-cycle expected control
    function automatic void build(bit [6:0] op, bit [2:0] f3, bit f7);
        cyc_t alu_wb;
        cyc_t mem_adr;
        alu_wb  = mk(7, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 1, A_ADD);
        mem_adr = mk(2, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, A_ADD);
        script.delete();
        script.push_back(mk(0, 1, 0, 0, 0, 1, 2'b10, 2'b00, 2'b10, 0, A_ADD));
        script.push_back(mk(1, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 0, A_ADD));
        case (op)
            OP_LW: begin
                script.push_back(mem_adr);
                script.push_back(mk(3, 0, 0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 0, A_ADD));
                script.push_back(mk(4, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 1, A_ADD));
            end
            OP_SW: begin
                script.push_back(mem_adr);
                script.push_back(mk(5, 0, 0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 0, A_ADD));
            end
            OP_R: begin
                script.push_back(mk(6, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, alu_expect(f3, 1, f7)));
                script.push_back(alu_wb);
            end
            OP_IALU: begin
                script.push_back(mk(8, 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 0, alu_expect(f3, 0, f7)));
                script.push_back(alu_wb);
            end
            OP_JAL: begin
                script.push_back(mk(9, 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 0, A_ADD));
                script.push_back(alu_wb);
            end
            OP_BEQ: begin
                script.push_back(mk(10, 0, 1, 0, 0, 0, 2'b00, 2'b10, 2'b00, 0, A_SUB));
            end
            default: ;
        endcase
    endfunction

    // zmode: -1 random zero flag, 0/1 forced; abort_at: cycle index to assert reset in
    task automatic run_instr(input bit [6:0] op, input bit [2:0] f3, input bit f7,
                             input int zmode, input int abort_at);
        build(op, f3, f7);
        bus.opcode   = op;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        for (int i = 0; i < script.size(); i++) begin
            cyc_t e;
            bit   z;
            bit   ab;
            e  = script[i];
            z  = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            ab = (i == abort_at);
            bus.zero = z;
            if (ab) reset = 1'b1;
            @(negedge clk);
            check("state",      32'(bus.state),      32'(e.st));
            check("PCWrite",    32'(bus.PCWrite),    ab ? 32'd0 : 32'(e.pcu | (e.br & taken(z, f3))));
            check("IRWrite",    32'(bus.IRWrite),    ab ? 32'd0 : 32'(e.irw));
            check("RegWrite",   32'(bus.RegWrite),   ab ? 32'd0 : 32'(e.rw));
            check("MemWrite",   32'(bus.MemWrite),   ab ? 32'd0 : 32'(e.mw));
            check("AdrSrc",     32'(bus.AdrSrc),     32'(e.adr));
            check("ResultSrc",  32'(bus.ResultSrc),  32'(e.rs));
            check("ALUSrcA",    32'(bus.ALUSrcA),    32'(e.a));
            check("ALUSrcB",    32'(bus.ALUSrcB),    32'(e.b));
            check("ALUControl", 32'(bus.ALUControl), 32'(e.alu));
            check("ImmSrc",     32'(bus.ImmSrc),     32'(imm_expect(op)));
            @(posedge clk);
            #1;
            if (ab) begin
                reset = 1'b0;
                return;
            end
        end
    endtask

    initial begin
        bit [6:0] op;
        bit [2:0] f3;
        bit       f7;

        reset        = 1'b1;
        bus.opcode   = OP_R;
        bus.funct3   = 3'b000;
        bus.funct7_5 = 1'b0;
        bus.zero     = 1'b1;

        repeat (2) begin
            @(negedge clk);
            check("rst.PCWrite",  32'(bus.PCWrite),  32'd0);
            check("rst.IRWrite",  32'(bus.IRWrite),  32'd0);
            check("rst.RegWrite", 32'(bus.RegWrite), 32'd0);
            check("rst.MemWrite", 32'(bus.MemWrite), 32'd0);
            check("rst.state",    32'(bus.state),    32'd0);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Directed cases from the plan, then randomized instruction stream
        run_instr(OP_R,    3'b000, 1'b0, -1, -1);
        run_instr(OP_R,    3'b000, 1'b1, -1, -1);
        run_instr(OP_LW,   3'b010, 1'b0, -1, -1);
        run_instr(OP_SW,   3'b010, 1'b0, -1, -1);
        run_instr(OP_BEQ,  3'b000, 1'b0,  1, -1);
        run_instr(OP_BEQ,  3'b000, 1'b0,  0, -1);
        run_instr(7'h7f,   3'b000, 1'b0, -1, -1);
        run_instr(OP_SW,   3'b010, 1'b0, -1,  3);
        run_instr(OP_IALU, 3'b000, 1'b1, -1, -1);
        run_instr(OP_JAL,  3'b000, 1'b0, -1, -1);
`ifdef BNE_EN
        run_instr(OP_BEQ,  3'b001, 1'b0,  0, -1);
`endif

        for (int n = 0; n < 400; n++) begin
            f3 = 3'($urandom_range(0, 7));
            f7 = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 6))
                0: op = OP_LW;
                1: op = OP_SW;
                2: op = OP_R;
                3: op = OP_IALU;
                4: op = OP_JAL;
                5: op = OP_BEQ;
                default: begin
                    do op = 7'($urandom_range(0, 127)); while (is_legal(op));
                end
            endcase
            run_instr(op, f3, f7, -1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1);
        end

        @(negedge clk);
        check("final.state", 32'(bus.state), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
